// File: rtl/y_word_packer.sv
// Packs the serial Y bit stream LSB-first into WIDTH-bit words.
// Completed or flushed words queue in a small FIFO with enable/ready out.
module y_word_packer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       Y_data,
    input  logic                       Y_enable,
    output logic                       Y_ready,
    input  logic                       flush,
    output logic [WIDTH-1:0]           W_data,
    output logic [$clog2(WIDTH+1)-1:0] W_count,
    output logic                       W_enable,
    input  logic                       W_ready,
    output logic [CNT_W-1:0]           ones_count,
    output logic [CNT_W-1:0]           word_count
);

    localparam int BW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH+1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_nx;
    logic [BW-1:0]    bit_cnt;
    logic [CW-1:0]    fill_nx;
    logic [WIDTH-1:0] mem_data [DEPTH];
    logic [CW-1:0]    mem_cnt  [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      occ;
    logic             alive;
    logic             full;
    logic             empty;
    logic             accept;
    logic             take_flush;
    logic             complete;
    logic             push;
    logic             pop;

    assign full       = (occ == FULL_OCC);
    assign empty      = (occ == '0);
    // alive keeps Y_ready low while reset is held and until the first edge after it
    assign Y_ready    = alive && !full;
    assign accept     = Y_enable && Y_ready;
    assign take_flush = flush && Y_ready;
    assign W_enable   = !empty;
    assign pop        = W_enable && W_ready;
    assign W_data     = empty ? '0 : mem_data[rd_ptr];
    assign W_count    = empty ? '0 : mem_cnt[rd_ptr];

    always_comb begin
        shift_nx = shift_q;
        if (accept)
            shift_nx[bit_cnt] = Y_data;
        fill_nx  = CW'(bit_cnt) + CW'(accept);
        complete = accept && (bit_cnt == BW'(WIDTH-1));
        push     = complete || (take_flush && (fill_nx != '0));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alive   <= 1'b0;
            shift_q <= '0;
            bit_cnt <= '0;
        end else begin
            alive <= 1'b1;
            if (push) begin
                shift_q <= '0;
                bit_cnt <= '0;
            end else if (accept) begin
                shift_q <= shift_nx;
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= shift_nx;
            mem_cnt[wr_ptr]  <= fill_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                occ <= occ + 1'b1;
            else if (pop && !push)
                occ <= occ - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ones_count <= '0;
            word_count <= '0;
        end else begin
            if (accept && Y_data && (ones_count != '1))
                ones_count <= ones_count + 1'b1;
            if (pop && (word_count != '1))
                word_count <= word_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_y_word_packer.sv
// Directed bench for y_word_packer: table of per-cycle vectors plus
// hand sequences for backpressure, reset, saturation and push/pop overlap.
module tb_y_word_packer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       yd = 1'b0, ye = 1'b0, fl = 1'b0, wr = 1'b0;
    logic       yr, we;
    logic [7:0] wd;
    logic [3:0] wc;
    logic [15:0] ones, words;

    logic       yd2 = 1'b0, ye2 = 1'b0, fl2 = 1'b0, wr2 = 1'b0;
    logic       yr2, we2;
    logic [7:0] wd2;
    logic [3:0] wc2;
    logic [3:0] ones2, words2;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    y_word_packer #(.WIDTH(8), .DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .Y_data(yd), .Y_enable(ye), .Y_ready(yr),
        .flush(fl), .W_data(wd), .W_count(wc), .W_enable(we), .W_ready(wr),
        .ones_count(ones), .word_count(words)
    );

    y_word_packer #(.WIDTH(8), .DEPTH(2), .CNT_W(4)) dut2 (
        .clk(clk), .reset(reset), .Y_data(yd2), .Y_enable(ye2), .Y_ready(yr2),
        .flush(fl2), .W_data(wd2), .W_count(wc2), .W_enable(we2), .W_ready(wr2),
        .ones_count(ones2), .word_count(words2)
    );

    typedef struct {
        logic       yd, ye, fl, wr;
        logic       yr, we;
        logic [7:0] wd;
        logic [3:0] wc;
        int         ones, words;
    } vec_t;

    vec_t tbl [19];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        ye = 0; fl = 0; wr = 0; ye2 = 0; fl2 = 0; wr2 = 0;
        #2 reset = 1;
        @(posedge clk);
        #2 reset = 0;
        cyc();
    endtask

    int sent, popped, stall;
    logic rel;
    logic [7:0] pat;

    initial begin
        tbl[0]  = '{1,1,0,1, 1,0,8'h00,0,1,0};
        tbl[1]  = '{0,1,0,1, 1,0,8'h00,0,1,0};
        tbl[2]  = '{1,1,0,1, 1,0,8'h00,0,2,0};
        tbl[3]  = '{1,1,0,1, 1,0,8'h00,0,3,0};
        tbl[4]  = '{0,1,0,1, 1,0,8'h00,0,3,0};
        tbl[5]  = '{0,1,0,1, 1,0,8'h00,0,3,0};
        tbl[6]  = '{1,1,0,1, 1,0,8'h00,0,4,0};
        tbl[7]  = '{0,1,0,1, 1,1,8'h4D,8,4,0};
        tbl[8]  = '{0,0,0,1, 1,0,8'h00,0,4,1};
        tbl[9]  = '{1,1,0,0, 1,0,8'h00,0,5,1};
        tbl[10] = '{1,1,0,0, 1,0,8'h00,0,6,1};
        tbl[11] = '{0,1,0,0, 1,0,8'h00,0,6,1};
        tbl[12] = '{0,0,1,0, 1,1,8'h03,3,6,1};
        tbl[13] = '{0,0,1,0, 1,1,8'h03,3,6,1};
        tbl[14] = '{0,0,0,1, 1,0,8'h00,0,6,2};
        tbl[15] = '{1,1,0,0, 1,0,8'h00,0,7,2};
        tbl[16] = '{0,1,0,0, 1,0,8'h00,0,7,2};
        tbl[17] = '{1,1,1,0, 1,1,8'h05,3,8,2};
        tbl[18] = '{0,0,0,1, 1,0,8'h00,0,8,3};

        // reset state
        #1;
        chk("rst_y_ready", yr, 0);
        chk("rst_w_enable", we, 0);
        chk("rst_w_data", wd, 0);
        chk("rst_w_count", wc, 0);
        chk("rst_counts", {ones, words}, 0);
        @(posedge clk);
        #2 reset = 0;
        cyc();
        chk("ready_after_rst", yr, 1);

        foreach (tbl[i]) begin
            yd = tbl[i].yd; ye = tbl[i].ye; fl = tbl[i].fl; wr = tbl[i].wr;
            cyc();
            chk($sformatf("v%0d_y_ready", i), yr, tbl[i].yr);
            chk($sformatf("v%0d_w_enable", i), we, tbl[i].we);
            chk($sformatf("v%0d_w_data", i), wd, tbl[i].wd);
            chk($sformatf("v%0d_w_count", i), wc, tbl[i].wc);
            chk($sformatf("v%0d_ones", i), ones, tbl[i].ones);
            chk($sformatf("v%0d_words", i), words, tbl[i].words);
        end
        fl = 0; ye = 0; wr = 0;

        // 7 bits then the 8th with flush: exactly one full word
        for (int i = 0; i < 7; i++) begin
            yd = 1; ye = 1; cyc();
        end
        yd = 0; ye = 1; fl = 1;
        cyc();
        ye = 0; fl = 0;
        chk("fl8_w_enable", we, 1);
        chk("fl8_w_data", wd, 8'h7F);
        chk("fl8_w_count", wc, 8);
        chk("fl8_ones", ones, 15);
        wr = 1;
        cyc();
        chk("fl8_pop_words", words, 4);
        chk("fl8_pop_empty", we, 0);
        cyc();
        chk("fl8_no_second", we, 0);
        chk("fl8_words_hold", words, 4);

        // backpressure
        do_reset();
        sent = 0; popped = 0; stall = 0; rel = 0;
        for (int c = 0; c < 300 && !(sent == 40 && popped == 5); c++) begin
            ye = (sent < 40); yd = 1; wr = rel;
            if (ye && yr) sent++;
            if (we && wr) begin
                chk("bp_data", wd, 8'hFF);
                chk("bp_count", wc, 8);
                popped++;
            end
            cyc();
            if (!rel && sent == 32) begin
                stall++;
                if (stall == 3) begin
                    chk("bp_ready_low", yr, 0);
                    rel = 1;
                end
            end
        end
        ye = 0; wr = 0;
        chk("bp_stalled", stall, 3);
        chk("bp_sent", sent, 40);
        chk("bp_popped", popped, 5);
        chk("bp_words", words, 5);
        chk("bp_ones", ones, 40);

        // reset mid-word with one word queued
        do_reset();
        for (int i = 0; i < 13; i++) begin
            yd = 1; ye = 1; cyc();
        end
        ye = 0;
        chk("pre_rst_w_enable", we, 1);
        #2 reset = 1;
        #1;
        chk("mid_rst_y_ready", yr, 0);
        chk("mid_rst_w_enable", we, 0);
        chk("mid_rst_w_data", wd, 0);
        chk("mid_rst_w_count", wc, 0);
        chk("mid_rst_ones", ones, 0);
        chk("mid_rst_words", words, 0);
        @(posedge clk);
        #2 reset = 0;
        cyc();
        chk("post_rst_ready", yr, 1);
        chk("post_rst_empty", we, 0);
        pat = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            yd = pat[i]; ye = 1; cyc();
        end
        ye = 0;
        chk("post_rst_w_data", wd, 8'hA5);
        chk("post_rst_w_count", wc, 8);
        chk("post_rst_ones", ones, 4);
        chk("post_rst_words", words, 0);
        wr = 1;
        cyc();
        wr = 0;
        chk("post_rst_pop_words", words, 1);
        chk("post_rst_pop_empty", we, 0);

        // saturation with continuous pop, small counters
        do_reset();
        wr2 = 1;
        for (int i = 0; i < 20; i++) begin
            yd2 = 1; ye2 = 1; cyc();
        end
        ye2 = 0; fl2 = 1; wr2 = 0;
        cyc();
        fl2 = 0;
        chk("sat_flush_data", wd2, 8'h0F);
        chk("sat_flush_count", wc2, 4);
        wr2 = 1;
        for (int i = 0; i < 3; i++) cyc();
        chk("sat_ones", ones2, 15);
        chk("sat_words", words2, 3);

        // push and pop together at occupancy 1
        wr2 = 0;
        for (int i = 0; i < 8; i++) begin
            yd2 = 1; ye2 = 1; cyc();
        end
        chk("cc_head_a", wd2, 8'hFF);
        pat = 8'h3C;
        for (int i = 0; i < 7; i++) begin
            yd2 = pat[i]; ye2 = 1; cyc();
        end
        yd2 = pat[7]; ye2 = 1; wr2 = 1;
        cyc();
        ye2 = 0;
        chk("cc_w_enable", we2, 1);
        chk("cc_head_b", wd2, 8'h3C);
        chk("cc_count_b", wc2, 8);
        chk("cc_words", words2, 4);
        cyc();
        chk("cc_drained", we2, 0);
        chk("cc_words_end", words2, 5);
        chk("cc_ones_sat", ones2, 15);
        wr2 = 0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/y_word_packer.md
Name: y_word_packer

Overview:
- Downstream consumer of the XOR stage's 1-bit Y stream.
- Accepts Y bits over the enable/ready handshake and packs them LSB-first into WIDTH-bit words.
- Buffers completed words in a DEPTH-entry FIFO and presents them as a word stream with enable/ready.
- Also keeps running statistics (ones seen, words delivered) for bench and debug visibility.

Parameters:
- WIDTH, 8, bits per packed word (>=2).
- DEPTH, 4, word FIFO entries (power of 2, >=2).
- CNT_W, 16, width of statistics counters.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- Y_data  in  1  serial result bit from XOR stage.
- Y_enable  in  1  Y_data valid.
- Y_ready  out  1  packer can accept a bit.
- flush  in  1  emit current partial word.
- W_data  out  WIDTH  head word, bit 0 = first bit received.
- W_count  out  $clog2(WIDTH+1)  number of valid bits in W_data (1..WIDTH).
- W_enable  out  1  W_data/W_count valid (FIFO not empty).
- W_ready  in  1  consumer accepts head word.
- ones_count  out  CNT_W  accepted Y bits equal to 1.
- word_count  out  CNT_W  words popped.

Behaviour:
- Interface:
  - One clock domain, clk.
  - reset is asynchronous and active-high.
  - Transfer occurs on a rising clk edge when enable and ready are both 1.
- Reset:
  - Async assert clears shift register, bit counter (bit_cnt), FIFO pointers and occupancy, ones_count and word_count.
  - While reset is high: Y_ready=0, W_enable=0, W_data=0, W_count=0.
  - Y_ready=1 from the first clk after deassert.
  - Reset mid-word or mid-drain discards all held data.
- Y_ready:
  - Y_ready = !fifo_full; it depends on state only.
  - No combinational path from W_ready or Y_enable to Y_ready.
- Bit accept (Y_enable && Y_ready):
  - shift[bit_cnt] <= Y_data and bit_cnt increments.
  - When bit_cnt == WIDTH-1, the accepted bit completes the word: push {shift with new bit, WIDTH} to FIFO, clear shift, bit_cnt <= 0.
- flush:
  - Sampled only when fifo_full == 0; ignored while full (caller holds it).
  - If bit_cnt == 0 and no bit is accepted that cycle: no-op.
  - Otherwise push the partial word, upper bits zero, W_count = bit_cnt (+1 if a bit is accepted the same cycle), and clear bit_cnt.
  - If the same-cycle bit completes the word, exactly one full word is pushed (count WIDTH); no second push.
- FIFO:
  - W_enable = !empty.
  - W_data/W_count are driven from registered storage at the read pointer.
  - Pop when W_enable && W_ready.
  - Push and pop in the same cycle: occupancy unchanged.
  - Push never occurs when full, since Y_ready=0 then.
  - Pointers wrap modulo DEPTH.
- Latency: word completed at edge N with the FIFO empty -> W_enable=1 from edge N (visible in cycle N+1).
- Statistics:
  - ones_count increments on each accepted bit with Y_data=1.
  - word_count increments on each pop.
  - Both counters saturate at 2^CNT_W-1 and never wrap.

Test Plan:
- Accept/pack, WIDTH=8, W_ready=1:
  - Stimulus: bits 1,0,1,1,0,0,1,0 on consecutive cycles.
  - Response: W_enable high the cycle after the 8th bit, W_data=0x4D, W_count=8; ones_count=4, word_count=1 after the pop.
- Backpressure, W_ready=0:
  - Stimulus: 40 consecutive 1-bits.
  - Response: Y_ready falls after bit 32 (4 words full); bits 33+ stall.
  - Then raise W_ready: four 0xFF words, then a fifth 0xFF word from the held-off bits.
  - End state: word_count=5, ones_count=40.
- Partial flush:
  - Stimulus: bits 1,1,0, then a flush pulse.
  - Response: W_data=0x03, W_count=3.
  - A second flush with bit_cnt=0 produces no word.
- Flush with same-cycle bit:
  - Stimulus: bits 1,0, then bit 1 with flush in the same cycle -> W_data=0x05, W_count=3.
  - Stimulus: 7 bits, then the 8th bit with flush -> exactly one word with W_count=8.
- Reset mid-word:
  - Stimulus: 5 bits accepted and one word queued, then pulse reset asynchronously between edges.
  - Response: all outputs 0 immediately.
  - After deassert, 8 new bits form a clean word and counters restart from 0.
- Saturation and concurrency, CNT_W=4, DEPTH=2:
  - Stimulus: 20 one-bits with continuous pop.
  - Response: ones_count holds at 15.
  - A push and pop in the same cycle at occupancy 1 keeps W_enable=1 with no lost or duplicated word.
